// File: rtl/ips2l_pcie_dma_wr_ctrl.sv
// ips2l_pcie_dma_wr_ctrl
// Takes a packed 128-bit DW payload stream and writes it into BAR RAM at a
// DW-granular start address. Payload DWs are shifted into the RAM's 128-bit
// lanes by the start offset (address bits [3:2]). Per-byte write enables are
// generated for the partial first and last words.
// A beat accepted in cycle N produces its RAM write in cycle N+1. When the
// offset pushes the payload into one more RAM word than there are input
// beats, an extra flush write drains the held previous beat.
// Optional build macro IPS2L_PCIE_DMA_WR_FBE_LBE_EN adds i_first_be and
// i_last_be. These refine the byte enables of the first and last DW.
module ips2l_pcie_dma_wr_ctrl #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_start,
    input  logic [9:0]            i_wr_length,
    input  logic [63:0]           i_wr_addr,
    input  logic [127:0]          i_wr_data,
    input  logic                  i_wr_data_vld,
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
    input  logic [3:0]            i_first_be,
    input  logic [3:0]            i_last_be,
`endif
    output logic                  o_wr_data_rdy,
    output logic                  o_bar_wr_en,
    output logic [ADDR_WIDTH-1:0] o_bar_wr_addr,
    output logic [127:0]          o_bar_wr_data,
    output logic [15:0]           o_bar_wr_be,
    output logic                  o_wr_busy,
    output logic                  o_wr_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state_reg;
    logic [10:0]           len_reg;
    logic [1:0]            off_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [8:0]            in_cnt_reg;
    logic [8:0]            ram_cnt_reg;
    logic                  flush_reg;
    logic                  first_reg;
    logic [127:0]          prev_reg;
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
    logic [3:0]            fbe_reg;
    logic [3:0]            lbe_reg;
`endif

    // Start-time decode of the request.
    logic [10:0] len_start;
    logic [1:0]  off_start;
    logic [10:0] sum_in;
    logic [10:0] sum_ram;
    logic [8:0]  in_beats_start;
    logic [8:0]  ram_beats_start;

    assign len_start       = (i_wr_length == 10'd0) ? 11'd1024 : {1'b0, i_wr_length};
    assign off_start       = i_wr_addr[3:2];
    assign sum_in          = len_start + 11'd3;
    assign sum_ram         = len_start + {9'd0, off_start} + 11'd3;
    assign in_beats_start  = sum_in[10:2];
    assign ram_beats_start = sum_ram[10:2];

    // Only the RAM word and DW offset bits of the byte address are meaningful here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_wr_addr[63:ADDR_WIDTH+4], i_wr_addr[1:0]};

    // Beat handshake and write issue.
    logic beat_acc;
    logic do_write;
    logic is_last;
    logic [1:0] last_lane;

    assign o_wr_data_rdy = (state_reg == WRITE) && (in_cnt_reg != 9'd0);
    assign beat_acc      = o_wr_data_rdy && i_wr_data_vld;
    assign do_write      = beat_acc || (state_reg == FLUSH);
    assign is_last       = (ram_cnt_reg == 9'd1);
    assign last_lane     = off_reg + len_reg[1:0] - 2'd1;

    // Realign {cur,prev} by the DW offset; a flush has no current beat.
    logic [127:0] cur;
    logic [127:0] data_next;
    always_comb begin
        cur       = (state_reg == FLUSH) ? 128'd0 : i_wr_data;
        data_next = cur;
        case (off_reg)
            2'd0:    data_next = cur;
            2'd1:    data_next = {cur[95:0], prev_reg[127:96]};
            2'd2:    data_next = {cur[63:0], prev_reg[127:64]};
            default: data_next = {cur[31:0], prev_reg[127:32]};
        endcase
    end

    // Per-lane byte enables for the write being issued.
    logic [15:0] be_next;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_on;
            logic [3:0] lane_be;
            assign lane_on = (!first_reg || (2'(gi) >= off_reg)) &&
                             (!is_last   || (2'(gi) <= last_lane));
            // Whole-DW enable, optionally narrowed for the first/last DW.
            always_comb begin
                lane_be = lane_on ? 4'hF : 4'h0;
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
                if (first_reg && (2'(gi) == off_reg))
                    lane_be = lane_be & fbe_reg;
                if (is_last && (2'(gi) == last_lane) && (len_reg != 11'd1))
                    lane_be = lane_be & lbe_reg;
`endif
            end
            assign be_next[4*gi +: 4] = lane_be;
        end
    endgenerate

    // Control FSM, counters and registered RAM write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            off_reg       <= '0;
            addr_reg      <= '0;
            in_cnt_reg    <= '0;
            ram_cnt_reg   <= '0;
            flush_reg     <= 1'b0;
            first_reg     <= 1'b0;
            prev_reg      <= '0;
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
            fbe_reg       <= '0;
            lbe_reg       <= '0;
`endif
            o_bar_wr_en   <= 1'b0;
            o_bar_wr_addr <= '0;
            o_bar_wr_data <= '0;
            o_bar_wr_be   <= '0;
            o_wr_busy     <= 1'b0;
            o_wr_done     <= 1'b0;
        end else begin
            o_bar_wr_en <= 1'b0;
            o_wr_done   <= 1'b0;
            // Busy falls the cycle after the done pulse.
            if (o_wr_done)
                o_wr_busy <= 1'b0;

            if (do_write) begin
                o_bar_wr_en   <= 1'b1;
                o_bar_wr_addr <= addr_reg;
                o_bar_wr_data <= data_next;
                o_bar_wr_be   <= be_next;
                addr_reg      <= addr_reg + 1'b1;
                ram_cnt_reg   <= ram_cnt_reg - 9'd1;
                first_reg     <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (i_wr_start) begin
                        len_reg     <= len_start;
                        off_reg     <= off_start;
                        addr_reg    <= i_wr_addr[ADDR_WIDTH+3:4];
                        in_cnt_reg  <= in_beats_start;
                        ram_cnt_reg <= ram_beats_start;
                        flush_reg   <= (ram_beats_start != in_beats_start);
                        first_reg   <= 1'b1;
                        prev_reg    <= '0;
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
                        fbe_reg     <= i_first_be;
                        lbe_reg     <= i_last_be;
`endif
                        o_wr_busy   <= 1'b1;
                        state_reg   <= WRITE;
                    end
                end
                WRITE: begin
                    if (beat_acc) begin
                        prev_reg   <= i_wr_data;
                        in_cnt_reg <= in_cnt_reg - 9'd1;
                        if (in_cnt_reg == 9'd1)
                            state_reg <= flush_reg ? FLUSH : DONE;
                    end
                end
                FLUSH: begin
                    state_reg <= DONE;
                end
                default: begin
                    o_wr_done <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ips2l_pcie_dma_wr_ctrl.sv
// tb_ips2l_pcie_dma_wr_ctrl
// Randomised scoreboard bench. The driver computes each transfer's expected
// RAM writes from the payload DW stream: leading offset zeros, the payload,
// then trailing zeros, cut into 128-bit words. It also computes the write
// and done cycles. A negedge monitor pops and compares them.
module tb_ips2l_pcie_dma_wr_ctrl;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_wr_start = 1'b0;
    logic [9:0]    i_wr_length = '0;
    logic [63:0]   i_wr_addr = '0;
    logic [127:0]  i_wr_data = '0;
    logic          i_wr_data_vld = 1'b0;
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
    logic [3:0]    i_first_be = 4'hF;
    logic [3:0]    i_last_be = 4'hF;
`endif
    logic          o_wr_data_rdy;
    logic          o_bar_wr_en;
    logic [AW-1:0] o_bar_wr_addr;
    logic [127:0]  o_bar_wr_data;
    logic [15:0]   o_bar_wr_be;
    logic          o_wr_busy;
    logic          o_wr_done;

    ips2l_pcie_dma_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_start    (i_wr_start),
        .i_wr_length   (i_wr_length),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_wr_data_vld (i_wr_data_vld),
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
        .i_first_be    (i_first_be),
        .i_last_be     (i_last_be),
`endif
        .o_wr_data_rdy (o_wr_data_rdy),
        .o_bar_wr_en   (o_bar_wr_en),
        .o_bar_wr_addr (o_bar_wr_addr),
        .o_bar_wr_data (o_bar_wr_data),
        .o_bar_wr_be   (o_bar_wr_be),
        .o_wr_busy     (o_wr_busy),
        .o_wr_done     (o_wr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
        logic [15:0]   be;
    } wr_t;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    wr_t exp_wr[$];
    int  exp_cyc[$];
    int  exp_done[$];
    wr_t mon_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // Monitor: compares every RAM write and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (o_bar_wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                flag("unexpected_write");
            end else begin
                mon_w = exp_wr.pop_front();
                chk("wr_addr", o_bar_wr_addr, mon_w.addr);
                chk("wr_data", o_bar_wr_data, mon_w.data);
                chk("wr_be",   o_bar_wr_be,   mon_w.be);
                if (exp_cyc.size() == 0) flag("write_without_accept");
                else chk("wr_cycle", cyc, exp_cyc.pop_front());
            end
            $display("[TB] write addr=%0d be=%h data=%h", o_bar_wr_addr, o_bar_wr_be, o_bar_wr_data);
        end
        if (o_wr_done === 1'b1) begin
            done_cnt++;
            chk("writes_left_at_done", exp_wr.size(), 0);
            if (exp_done.size() == 0) flag("unexpected_done");
            else chk("done_cycle", cyc, exp_done.pop_front());
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, {o_bar_wr_en, o_bar_wr_addr, o_bar_wr_be, o_wr_busy, o_wr_done, o_wr_data_rdy}, '0);
        chk({name, "_data"}, o_bar_wr_data, '0);
    endtask

    // vmode: 0 continuous valid, 1 toggled valid, 2 random valid.
    // abort_after > 0 applies reset once that many beats have been written.
    task automatic xfer(input logic [63:0] addr, input logic [9:0] length,
                        input int vmode, input bit mid_start, input int abort_after);
        int len, off, inb, ramb, word, sent, guard, last_acc, dc, p;
        bit tog, v;
        logic [127:0] beats[$];
        logic [31:0]  s[$];
        logic [3:0]   b;
        logic [3:0]   fbe, lbe;
        wr_t w;
        len  = (length == 10'd0) ? 1024 : int'(length);
        off  = int'(addr[3:2]);
        inb  = (len + 3) / 4;
        ramb = (len + off + 3) / 4;
        word = int'(addr[AW+3:4]);
        fbe  = 4'hF;
        lbe  = 4'hF;
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
        fbe  = 4'($urandom);
        lbe  = 4'($urandom);
        i_first_be = fbe;
        i_last_be  = lbe;
`endif
        for (int i = 0; i < inb; i++)
            beats.push_back({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < off; i++) s.push_back(32'd0);
        for (int i = 0; i < inb; i++)
            for (int j = 0; j < 4; j++) s.push_back(beats[i][32*j +: 32]);
        while (s.size() < 4 * ramb) s.push_back(32'd0);
        for (int k = 0; k < ramb; k++) begin
            w.addr = AW'((word + k) % (1 << AW));
            w.data = {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]};
            for (int l = 0; l < 4; l++) begin
                p = 4 * k + l;
                b = (p >= off && p < off + len) ? 4'hF : 4'h0;
`ifdef IPS2L_PCIE_DMA_WR_FBE_LBE_EN
                if (p == off) b = b & fbe;
                if (len > 1 && p == off + len - 1) b = b & lbe;
`endif
                w.be[4*l +: 4] = b;
            end
            exp_wr.push_back(w);
        end
        $display("[TB] start addr=%h len=%0d off=%0d in_beats=%0d ram_beats=%0d fbe=%h lbe=%h",
                 addr, len, off, inb, ramb, fbe, lbe);

        // Start pulse with a junk beat offered while not ready.
        @(negedge clk);
        i_wr_start    = 1'b1;
        i_wr_addr     = addr;
        i_wr_length   = length;
        i_wr_data_vld = 1'b1;
        i_wr_data     = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        i_wr_start = 1'b0;
        chk("busy_after_start", o_wr_busy, 1'b1);

        sent = 0; guard = 0; tog = 1'b1; last_acc = cyc;
        while (sent < inb && guard < 4000 && !(abort_after > 0 && sent == abort_after)) begin
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = ($urandom_range(2) != 0);
            endcase
            i_wr_data_vld = v;
            i_wr_data     = v ? beats[sent] : {$urandom, $urandom, $urandom, $urandom};
            if (mid_start) begin
                i_wr_start  = ($urandom_range(5) == 0);
                i_wr_addr   = {$urandom, $urandom};
                i_wr_length = 10'($urandom);
            end
            if (v && o_wr_data_rdy === 1'b1) begin
                exp_cyc.push_back(cyc + 1);
                last_acc = cyc + 1;
                sent++;
            end
            guard++;
            @(negedge clk);
        end
        i_wr_data_vld = 1'b0;
        i_wr_start    = 1'b0;

        if (abort_after > 0) begin
            #2;
            rst = 1'b1;
            chk("writes_before_reset", exp_wr.size(), ramb - abort_after);
            @(negedge clk);
            chk_all_zero("outputs_in_reset");
            exp_wr.delete();
            exp_cyc.delete();
            exp_done.delete();
            rst = 1'b0;
            dc = done_cnt;
            repeat (10) @(negedge clk);
            chk("no_done_after_reset", done_cnt, dc);
            chk("idle_after_reset", {o_wr_busy, o_wr_data_rdy}, 2'b00);
            return;
        end

        if (sent < inb) begin
            flag("beat_timeout");
            exp_wr.delete();
            exp_cyc.delete();
            return;
        end
        if (ramb > inb) exp_cyc.push_back(last_acc + 1);
        exp_done.push_back(last_acc + ((ramb > inb) ? 2 : 1));

        dc = done_cnt; guard = 0;
        while (done_cnt == dc && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (done_cnt == dc) begin
            flag("done_timeout");
            exp_wr.delete();
            exp_cyc.delete();
            exp_done.delete();
        end
        @(negedge clk);
        chk("busy_after_done", o_wr_busy, 1'b0);
        chk("single_done", done_cnt, dc + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset_release");

        xfer(64'h0000, 10'd8, 0, 1'b0, 0);
        xfer(64'h0008, 10'd4, 0, 1'b0, 0);
        xfer(64'h0004, 10'd1, 0, 1'b0, 0);
        xfer(64'(300 << 4), 10'd0, 1, 1'b0, 0);
        xfer(64'h000C, 10'd6, 0, 1'b0, 0);
        xfer({$urandom, $urandom}, 10'd40, 2, 1'b1, 0);
        xfer(64'h0100, 10'd64, 0, 1'b1, 3);
        xfer(64'h1234, 10'd5, 0, 1'b0, 0);
        for (int t = 0; t < 25; t++)
            xfer({$urandom, $urandom}, 10'($urandom_range(80, 1)), $urandom_range(2),
                 1'($urandom_range(1)), 0);

        chk("scoreboard_empty", exp_wr.size() + exp_cyc.size() + exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
